// File: rtl/user_stream_arbiter.sv
// user_stream_arbiter: round-robin sharing of one output stream
// among NUM_REQ ap_vld/ap_ack producers, bounded bursts per grant.
module user_stream_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int PAYLOAD_BITS = 32,
    parameter int REQ_BITS     = 2,
    parameter int BURST_LEN    = 16
) (
    input  logic                            clk_user,
    input  logic                            reset,
    input  logic [NUM_REQ*PAYLOAD_BITS-1:0] din_req,
    input  logic [NUM_REQ-1:0]              vld_req,
    output logic [NUM_REQ-1:0]              ack_req,
    output logic [PAYLOAD_BITS-1:0]         dout,
    output logic                            vld_out,
    input  logic                            ack_out,
    output logic [REQ_BITS-1:0]             grant_id,
    output logic                            busy
);

    localparam int CNT_W = $clog2(BURST_LEN + 1);

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } state_t;

    state_t                  state_q;
    logic                    busy_q;
    logic [REQ_BITS-1:0]     grant_q;
    logic [REQ_BITS-1:0]     last_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [PAYLOAD_BITS-1:0] dout_q;
    logic                    vld_q;

    logic                    sel_vld;
    logic [PAYLOAD_BITS-1:0] sel_din;
    logic                    space;
    logic                    accept;
    logic                    last_beat;
    logic                    any_req;
    logic [REQ_BITS-1:0]     pick;
    logic [31:0]             scan;

    // Mux the granted requester's valid and data onto the output path
    always_comb begin
        sel_vld = 1'b0;
        sel_din = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == REQ_BITS'(i)) begin
                sel_vld = vld_req[i];
                sel_din = din_req[i*PAYLOAD_BITS +: PAYLOAD_BITS];
            end
        end
    end

    assign space     = !vld_q || ack_out;
    assign accept    = (state_q == S_GRANT) && sel_vld && space;
    assign last_beat = (cnt_q == CNT_W'(BURST_LEN - 1));

    // Combinational handshake back to the granted producer only
    always_comb begin
        ack_req = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            ack_req[i] = accept && (grant_q == REQ_BITS'(i));
        end
    end

    // Cyclic search for the first requester after the last one served
    always_comb begin
        any_req = 1'b0;
        pick    = '0;
        scan    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan = (32'(last_q) + 32'(k)) % 32'(NUM_REQ);
            if (!any_req && vld_req[scan[REQ_BITS-1:0]]) begin
                any_req = 1'b1;
                pick    = scan[REQ_BITS-1:0];
            end
        end
    end

    // Grant FSM: arbitrate in IDLE, stream a bounded burst in GRANT
    always_ff @(posedge clk_user) begin
        if (reset) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            grant_q <= '0;
            cnt_q   <= '0;
            last_q  <= REQ_BITS'(NUM_REQ - 1);
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (any_req) begin
                        grant_q <= pick;
                        cnt_q   <= '0;
                        state_q <= S_GRANT;
                        busy_q  <= 1'b1;
                    end
                end
                S_GRANT: begin
                    if (accept) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (last_beat) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                            last_q  <= grant_q;
                        end
                    end else if (!sel_vld) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        last_q  <= grant_q;
                    end
                end
            endcase
        end
    end

    // One-entry output register: load on accept, drain on ack_out
    always_ff @(posedge clk_user) begin
        if (reset) begin
            vld_q  <= 1'b0;
            dout_q <= '0;
        end else if (accept) begin
            vld_q  <= 1'b1;
            dout_q <= sel_din;
        end else if (ack_out) begin
            vld_q  <= 1'b0;
        end
    end

    assign dout     = dout_q;
    assign vld_out  = vld_q;
    assign grant_id = grant_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_user_stream_arbiter.sv
// tb_user_stream_arbiter: directed scenarios plus random traffic
// against a transaction-level model of the arbiter.
module tb_user_stream_arbiter;

    logic         clk;
    logic         reset;
    logic [127:0] din_req;
    logic [3:0]   vld_req;
    logic [3:0]   ack_req;
    logic [31:0]  dout;
    logic         vld_out;
    logic         ack_out;
    logic [1:0]   grant_id;
    logic         busy;

    logic         rst1;
    logic [127:0] din1;
    logic [3:0]   vld1;
    logic [3:0]   ack1;
    logic [31:0]  dout1;
    logic         vo1;
    logic         ao1;
    logic [1:0]   gid1;
    logic         busy1;

    user_stream_arbiter #(
        .NUM_REQ(4), .PAYLOAD_BITS(32), .REQ_BITS(2), .BURST_LEN(16)
    ) u_dut (
        .clk_user(clk), .reset(reset),
        .din_req(din_req), .vld_req(vld_req), .ack_req(ack_req),
        .dout(dout), .vld_out(vld_out), .ack_out(ack_out),
        .grant_id(grant_id), .busy(busy)
    );

    user_stream_arbiter #(
        .NUM_REQ(4), .PAYLOAD_BITS(32), .REQ_BITS(2), .BURST_LEN(1)
    ) u_dut1 (
        .clk_user(clk), .reset(rst1),
        .din_req(din1), .vld_req(vld1), .ack_req(ack1),
        .dout(dout1), .vld_out(vo1), .ack_out(ao1),
        .grant_id(gid1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Transaction-level model: who holds the grant, how many words
    // it has moved, and what sits in the one-word output buffer.
    bit          m_busy;
    bit          m_full;
    int          m_g;
    int          m_words;
    int          m_last;
    logic [31:0] m_dout;
    int          seq[4];
    bit          prev_busy;
    int          gq[$];
    logic [31:0] dq[$];

    function automatic logic [31:0] word(input int i);
        return (32'(i) << 24) | 32'(seq[i]);
    endfunction

    function automatic logic [3:0] exp_ack();
        logic [3:0] a;
        a = 4'b0;
        if (m_busy && vld_req[m_g] && (!m_full || ack_out))
            a[m_g] = 1'b1;
        return a;
    endfunction

    task automatic model_reset();
        m_busy  = 1'b0;
        m_full  = 1'b0;
        m_g     = 0;
        m_words = 0;
        m_last  = 3;
        m_dout  = '0;
    endtask

    task automatic model_step();
        logic [3:0]  a;
        logic [31:0] w;
        int          idx;
        a = exp_ack();
        w = word(m_g);
        if (a != 4'b0) seq[m_g]++;
        if (reset) begin
            model_reset();
        end else if (!m_busy) begin
            if (vld_req != 4'b0) begin
                for (int k = 1; k <= 4; k++) begin
                    idx = (m_last + k) % 4;
                    if (!m_busy && vld_req[idx]) begin
                        m_busy  = 1'b1;
                        m_g     = idx;
                        m_words = 0;
                    end
                end
            end
            if (ack_out) m_full = 1'b0;
        end else if (a != 4'b0) begin
            m_dout = w;
            m_full = 1'b1;
            m_words++;
            if (m_words == 16) begin
                m_busy = 1'b0;
                m_last = m_g;
            end
        end else begin
            if (ack_out) m_full = 1'b0;
            if (!vld_req[m_g]) begin
                m_busy = 1'b0;
                m_last = m_g;
            end
        end
    endtask

    task automatic check_outputs();
        check("busy", 32'(busy), 32'(m_busy));
        check("grant_id", 32'(grant_id), 32'(m_g));
        check("vld_out", 32'(vld_out), 32'(m_full));
        check("dout", dout, m_dout);
    endtask

    // One clock: drive at negedge, check ack, advance model, check outputs
    task automatic cycle(input logic [3:0] v, input logic ao,
                         input logic r);
        vld_req = v;
        ack_out = ao;
        reset   = r;
        for (int i = 0; i < 4; i++) din_req[i*32 +: 32] = word(i);
        #1;
        check("ack_req", 32'(ack_req), 32'(exp_ack()));
        model_step();
        @(negedge clk);
        check_outputs();
        if (busy && !prev_busy) gq.push_back(32'(grant_id));
        if (vld_out) dq.push_back(dout);
        prev_busy = busy;
    endtask

    logic [3:0] v;
    logic       ao;
    logic       r;

    initial begin
        reset   = 1'b1;
        vld_req = '0;
        ack_out = 1'b0;
        din_req = '0;
        rst1    = 1'b1;
        vld1    = '0;
        ao1     = 1'b0;
        din1    = '0;
        for (int i = 0; i < 4; i++) seq[i] = 0;
        prev_busy = 1'b0;
        model_reset();
        @(negedge clk);
        check_outputs();
        check("ack_req_rst", 32'(ack_req), 32'h0);

        // Single requester, 20 words: 16-word burst, gap, 4 words
        seq[0] = 'h100;
        gq.delete();
        dq.delete();
        for (int c = 0; c < 26; c++)
            cycle((seq[0] < 'h114) ? 4'b0001 : 4'b0000, 1'b1, 1'b0);
        check("single_words", 32'(dq.size()), 32'd20);
        for (int k = 0; k < dq.size() && k < 20; k++)
            check("single_seq", dq[k], 32'h100 + 32'(k));
        check("single_grants", 32'(gq.size()), 32'd2);

        // Round robin with every requester valid
        cycle(4'b0000, 1'b1, 1'b1);
        gq.delete();
        for (int c = 0; c < 70; c++) cycle(4'b1111, 1'b1, 1'b0);
        check("rr_grants", 32'(gq.size()), 32'd5);
        for (int k = 0; k < gq.size() && k < 5; k++)
            check("rr_order", 32'(gq[k]), 32'(k % 4));

        // Backpressure in the middle of a burst
        cycle(4'b0000, 1'b1, 1'b1);
        for (int c = 0; c < 6; c++) cycle(4'b0001, 1'b1, 1'b0);
        for (int c = 0; c < 5; c++) begin
            cycle(4'b0001, 1'b0, 1'b0);
            check("bp_hold_ack", 32'(ack_req), 32'h0);
        end
        for (int c = 0; c < 8; c++) cycle(4'b0001, 1'b1, 1'b0);

        // Early release by requester 2 while 3 waits
        cycle(4'b0000, 1'b1, 1'b1);
        gq.delete();
        for (int c = 0; c < 4; c++) cycle(4'b1100, 1'b1, 1'b0);
        cycle(4'b1000, 1'b1, 1'b0);
        for (int c = 0; c < 80; c++) cycle(4'b1111, 1'b1, 1'b0);
        check("er_grants", 32'(gq.size() >= 5), 32'd1);
        if (gq.size() >= 5) begin
            check("er_g0", 32'(gq[0]), 32'd2);
            check("er_g1", 32'(gq[1]), 32'd3);
            check("er_g2", 32'(gq[2]), 32'd0);
            check("er_g3", 32'(gq[3]), 32'd1);
            check("er_g4", 32'(gq[4]), 32'd2);
        end

        // Reset while a word is stuck in the output buffer
        cycle(4'b0000, 1'b1, 1'b1);
        for (int c = 0; c < 3; c++) cycle(4'b1000, 1'b1, 1'b0);
        cycle(4'b1000, 1'b0, 1'b0);
        check("rm_full", 32'(vld_out), 32'd1);
        cycle(4'b1001, 1'b0, 1'b1);
        check("rm_vld", 32'(vld_out), 32'd0);
        check("rm_busy", 32'(busy), 32'd0);
        check("rm_gid", 32'(grant_id), 32'd0);
        cycle(4'b1001, 1'b1, 1'b0);
        check("rm_first", 32'(grant_id), 32'd0);
        check("rm_first_busy", 32'(busy), 32'd1);

        // Random traffic
        v = 4'b0000;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 7) == 0) v[i] = ~v[i];
            ao = ($urandom_range(0, 3) != 0);
            r  = ($urandom_range(0, 199) == 0);
            cycle(v, ao, r);
        end

        // BURST_LEN=1 instance alternating between requesters 0 and 1
        din1[31:0]  = 32'hA0;
        din1[63:32] = 32'hB1;
        rst1 = 1'b1;
        @(negedge clk);
        rst1 = 1'b0;
        vld1 = 4'b0011;
        ao1  = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check("b1_vld", 32'(vo1), 32'(k % 2 == 0));
            check("b1_busy", 32'(busy1), 32'(k % 2 == 1));
            check("b1_gid", 32'(gid1), 32'(((k - 1) / 2) % 2));
            if (k % 2 == 0)
                check("b1_dout", dout1,
                      (((k - 1) / 2) % 2 == 1) ? 32'hB1 : 32'hA0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
